// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - word-addressed synchronous RAM responder with pipelined read latency
//
// Purpose: memory-side responder for the core RAM port. It holds a word-addressed
// synchronous RAM and returns read data READ_LATENCY cycles after the request. Writes
// commit at the clock edge. It flags bad addresses and counts read and write traffic.
//
// Ports:
//   clk            clock, all state on the rising edge
//   rst            asynchronous active-low reset
//   ram_en_i       read request this cycle
//   ram_raddr_i    read byte address
//   ram_rdata_o    read data (holds its last value between responses)
//   rdata_valid_o  ram_rdata_o carries a response this cycle
//   ram_wen_i      write request this cycle (independent of ram_en_i)
//   ram_waddr_i    write byte address
//   ram_wdata_i    write data
//   rd_err_o       response this cycle was out-of-range or misaligned
//   wr_err_o       sticky flag: a write was rejected since reset
//   rd_count_o     accepted reads, wrapping
//   wr_count_o     committed writes, wrapping
//
// READ_LATENCY must be in the range 1..4.
module ram_responder #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          DEPTH_LOG2   = 12,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ram_en_i,
  input  logic [31:0]           ram_raddr_i,
  output logic [DATA_WIDTH-1:0] ram_rdata_o,
  output logic                  rdata_valid_o,
  input  logic                  ram_wen_i,
  input  logic [31:0]           ram_waddr_i,
  input  logic [DATA_WIDTH-1:0] ram_wdata_i,
  output logic                  rd_err_o,
  output logic                  wr_err_o,
  output logic [15:0]           rd_count_o,
  output logic [15:0]           wr_count_o
);

  localparam int          WORDS = 1 << DEPTH_LOG2;
  // Byte span of the window. It is 33 bits wide so that the compare below is exact
  // even when the window reaches 4 GiB.
  localparam logic [32:0] SPAN  = 33'd4 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Offsets use 32-bit wrapping subtraction. An address below BASE_ADDR therefore
  // becomes a huge offset and fails the range check.
  logic [31:0]           r_off;
  logic [31:0]           w_off;
  logic                  r_legal;
  logic                  w_legal;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_commit;
  logic                  w_reject;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_stage0;

  assign r_off    = ram_raddr_i - BASE_ADDR;
  assign w_off    = ram_waddr_i - BASE_ADDR;
  assign r_legal  = (ram_raddr_i[1:0] == 2'b00) && ({1'b0, r_off} < SPAN);
  assign w_legal  = (ram_waddr_i[1:0] == 2'b00) && ({1'b0, w_off} < SPAN);
  assign r_idx    = r_off[DEPTH_LOG2+1:2];
  assign w_idx    = w_off[DEPTH_LOG2+1:2];
  assign w_commit = ram_wen_i && w_legal;
  assign w_reject = ram_wen_i && !w_legal;

  // Write-first bypass: a read of the word being written in the same cycle
  // returns the new data.
  assign rd_word   = (w_commit && (w_idx == r_idx)) ? ram_wdata_i : mem[r_idx];
  assign rd_stage0 = r_legal ? rd_word : '0;

  // The RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      mem[w_idx] <= ram_wdata_i;
    end
  end

  // Latency pipeline. The RAM is read at acceptance into stage 0, and later stages
  // only delay the result. A data stage loads only when its upstream stage holds a
  // response, so the last stage keeps the previous data between responses.
  logic                  pipe_v [READ_LATENCY];
  logic                  pipe_e [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_d [READ_LATENCY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_e[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= ram_en_i;
      pipe_e[0] <= ram_en_i && !r_legal;
      if (ram_en_i) begin
        pipe_d[0] <= rd_stage0;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
        if (pipe_v[i-1]) begin
          pipe_d[i] <= pipe_d[i-1];
        end
      end
    end
  end

  assign rdata_valid_o = pipe_v[READ_LATENCY-1];
  assign rd_err_o      = pipe_e[READ_LATENCY-1];
  assign ram_rdata_o   = pipe_d[READ_LATENCY-1];

  // Traffic counters wrap naturally. Every accepted read counts, legal or not.
  // Only committed writes count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count_o <= 16'd0;
      wr_count_o <= 16'd0;
      wr_err_o   <= 1'b0;
    end else begin
      if (ram_en_i) begin
        rd_count_o <= rd_count_o + 16'd1;
      end
      if (w_commit) begin
        wr_count_o <= wr_count_o + 16'd1;
      end
      if (w_reject) begin
        wr_err_o <= 1'b1;
      end
    end
  end

endmodule
